// File: rtl/hw_stream_uart_if.sv
// hw_stream_uart_if: Avalon-MM slave bus plus TX/RX valid/ready streams for hw_stream_uart.
//
// Handshakes:
//   Avalon-MM: an access starts when chipselect and a low read_n/write_n strobe are
//   seen while waitrequest=1. The following cycle drives waitrequest=0 with readdata
//   valid. The master keeps its request stable until it sees waitrequest=0.
//   Streams: a word moves on a rising clk edge when valid and ready are both high.
//   The source holds data stable while valid & ~ready. Valid never waits on ready.
interface hw_stream_uart_if #(
    parameter int DATA_W = 8
);
    logic [1:0]        av_address;
    logic              av_chipselect;
    logic              av_read_n;
    logic              av_write_n;
    logic [31:0]       av_writedata;
    logic [31:0]       av_readdata;
    logic              av_waitrequest;
    logic              av_irq;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              dbg_acc_state;

    modport slave (
        input  av_address, av_chipselect, av_read_n, av_write_n, av_writedata,
        output av_readdata, av_waitrequest, av_irq,
        output tx_data, tx_valid,
        input  tx_ready,
        input  rx_data, rx_valid,
        output rx_ready,
        output dbg_acc_state
    );

    modport master (
        output av_address, av_chipselect, av_read_n, av_write_n, av_writedata,
        input  av_readdata, av_waitrequest, av_irq,
        input  tx_data, tx_valid,
        output tx_ready,
        output rx_data, rx_valid,
        input  rx_ready,
        input  dbg_acc_state
    );
endinterface

// File: rtl/hw_stream_uart.sv
// hw_stream_uart: Avalon-MM register front end with a TX FIFO (host to stream) and an
// RX FIFO (stream to host), IRQ thresholds and sticky error flags.
// Optional RX idle timeout is built when HW_STREAM_UART_RXTO_EN is defined.
module hw_stream_uart #(
    parameter int DATA_W = 8,
    parameter int TX_AW  = 6,
    parameter int RX_AW  = 6
) (
    input logic             clk,
    input logic             rst_n,
    hw_stream_uart_if.slave bus
);
    localparam int TX_DEPTH = 1 << TX_AW;
    localparam int RX_DEPTH = 1 << RX_AW;

    typedef enum logic {ACC_IDLE = 1'b0, ACC_ACK = 1'b1} acc_state_t;
    acc_state_t acc_state_q, acc_state_d;
    logic       waitrequest;

    logic acc_begin, rd_begin, wr_begin;
    logic wr_data, rd_data, wr_ctrl, wr_thr;

    // TX FIFO: level counts every word still owed to the stream, including the head
    // word already presented in the show-ahead register.
    logic [DATA_W-1:0] tx_mem [TX_DEPTH];
    logic [TX_AW-1:0]  tx_wr_ptr, tx_rd_ptr, tx_rd_addr;
    logic [TX_AW:0]    tx_count;
    logic              tx_push, tx_pop, tx_valid_q;
    logic [DATA_W-1:0] tx_data_q;

    logic [DATA_W-1:0] rx_mem [RX_DEPTH];
    logic [RX_AW-1:0]  rx_wr_ptr, rx_rd_ptr;
    logic [RX_AW:0]    rx_count;
    logic              rx_push, rx_pop, rx_empty;

    logic [2:0]  ien;
    logic [15:0] rx_thr, tx_thr;
    logic        tx_ovf, rx_unf;
    logic        ip_rx, ip_tx, ip_err, ien_to, ip_to;
    logic        irq_q;
    logic [31:0] rd_mux, rd_q;
    logic [15:0] tx_level16, rx_level16, tx_free16;
    logic [14:0] rx_head15;

    assign acc_begin = bus.av_chipselect & (~bus.av_read_n | ~bus.av_write_n) & (acc_state_q == ACC_IDLE);
    assign rd_begin  = acc_begin & ~bus.av_read_n;
    assign wr_begin  = acc_begin & ~bus.av_write_n;
    assign wr_data   = wr_begin & (bus.av_address == 2'd0);
    assign rd_data   = rd_begin & (bus.av_address == 2'd0);
    assign wr_ctrl   = wr_begin & (bus.av_address == 2'd1);
    assign wr_thr    = wr_begin & (bus.av_address == 2'd2);

    // Access FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) acc_state_q <= ACC_IDLE;
        else        acc_state_q <= acc_state_d;
    end

    // Access FSM: every access is one begin cycle followed by one acknowledge cycle.
    always_comb begin
        acc_state_d = acc_state_q;
        waitrequest = 1'b1;
        case (acc_state_q)
            ACC_IDLE: if (acc_begin) acc_state_d = ACC_ACK;
            ACC_ACK: begin
                waitrequest = 1'b0;
                acc_state_d = ACC_IDLE;
            end
            default: acc_state_d = ACC_IDLE;
        endcase
    end

    // Full is judged on the registered count, so a same-cycle pop never frees a slot.
    assign tx_push    = wr_data & ~tx_count[TX_AW];
    assign tx_pop     = tx_valid_q & bus.tx_ready;
    assign tx_rd_addr = tx_pop ? tx_rd_ptr + 1'b1 : tx_rd_ptr;

    // TX storage array.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= bus.av_writedata[DATA_W-1:0];
    end

    // TX pointers and level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
            tx_count <= tx_count + {{TX_AW{1'b0}}, tx_push} - {{TX_AW{1'b0}}, tx_pop};
        end
    end

    // Show-ahead register: refill straight from the next entry on a transfer so the
    // stream runs at one word per cycle; otherwise load the head once it is stored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else if (tx_pop) begin
            tx_valid_q <= (tx_count[TX_AW:1] != '0);
            if (tx_count[TX_AW:1] != '0) tx_data_q <= tx_mem[tx_rd_addr];
        end else if (!tx_valid_q && tx_count != '0) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= tx_mem[tx_rd_addr];
        end
    end

    assign rx_empty = (rx_count == '0);
    assign rx_push  = bus.rx_valid & ~rx_count[RX_AW];
    assign rx_pop   = rd_data & ~rx_empty;

    // RX storage array.
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= bus.rx_data;
    end

    // RX pointers and level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
            rx_count <= rx_count + {{RX_AW{1'b0}}, rx_push} - {{RX_AW{1'b0}}, rx_pop};
        end
    end

    // Zero-extended views of levels and RX head word for the register map.
    always_comb begin
        tx_level16 = '0;
        rx_level16 = '0;
        rx_head15  = '0;
        tx_level16[TX_AW:0] = tx_count;
        rx_level16[RX_AW:0] = rx_count;
        if (!rx_empty) rx_head15[DATA_W-1:0] = rx_mem[rx_rd_ptr];
        tx_free16 = 16'(TX_DEPTH) - tx_level16;
    end

    assign ip_rx  = (rx_thr != '0) & (rx_level16 >= rx_thr);
    assign ip_tx  = (tx_level16 <= tx_thr);
    assign ip_err = tx_ovf | rx_unf;

`ifdef HW_STREAM_UART_RXTO_EN
    logic [15:0] to_cnt, to_val;
    logic        ien_to_q, ip_to_q;
    logic        wr_to;

    assign wr_to = wr_begin & (bus.av_address == 2'd3);

    // RX idle timeout: count idle cycles while RX holds data; flag once at TO_VAL.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt   <= '0;
            to_val   <= 16'hFFFF;
            ien_to_q <= 1'b0;
            ip_to_q  <= 1'b0;
        end else begin
            if (rx_push || rd_data) to_cnt <= '0;
            else if (!rx_empty)     to_cnt <= to_cnt + 16'd1;
            if (wr_to)   to_val   <= bus.av_writedata[15:0];
            if (wr_ctrl) ien_to_q <= bus.av_writedata[3];
            if (rd_data) ip_to_q <= 1'b0;
            else if (to_val != '0 && to_cnt == to_val) ip_to_q <= 1'b1;
        end
    end

    assign ien_to = ien_to_q;
    assign ip_to  = ip_to_q;
`else
    assign ien_to = 1'b0;
    assign ip_to  = 1'b0;
`endif

    // Read mux, evaluated with the state seen in the begin cycle.
    always_comb begin
        rd_mux = '0;
        case (bus.av_address)
            2'd0: rd_mux = {rx_level16, ~rx_empty, rx_head15};
            2'd1: rd_mux = {tx_free16, 3'b000, ip_to, rx_unf, tx_ovf, ip_tx, ip_rx,
                            4'b0000, ien_to, ien};
            2'd2: rd_mux = {tx_thr, rx_thr};
            2'd3: rd_mux = {rx_level16, tx_level16};
            default: rd_mux = '0;
        endcase
    end

    // Control, thresholds, sticky flags (set beats write-1-clear), IRQ and read data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ien    <= '0;
            rx_thr <= 16'd8;
            tx_thr <= 16'd8;
            tx_ovf <= 1'b0;
            rx_unf <= 1'b0;
            irq_q  <= 1'b0;
            rd_q   <= '0;
        end else begin
            if (wr_ctrl) ien <= bus.av_writedata[2:0];
            if (wr_thr) begin
                rx_thr <= bus.av_writedata[15:0];
                tx_thr <= bus.av_writedata[31:16];
            end
            tx_ovf <= (tx_ovf & ~(wr_ctrl & bus.av_writedata[10])) | (wr_data & tx_count[TX_AW]);
            rx_unf <= (rx_unf & ~(wr_ctrl & bus.av_writedata[11])) | (rd_data & rx_empty);
            irq_q  <= |(ien & {ip_err, ip_tx, ip_rx}) | (ien_to & ip_to);
            rd_q   <= rd_begin ? rd_mux : '0;
        end
    end

    assign bus.av_waitrequest = waitrequest;
    assign bus.av_readdata    = rd_q;
    assign bus.av_irq         = irq_q;
    assign bus.tx_valid       = tx_valid_q;
    assign bus.tx_data        = tx_data_q;
    assign bus.rx_ready       = ~rx_count[RX_AW];
    assign bus.dbg_acc_state  = acc_state_q;
endmodule

// File: tb/tb_hw_stream_uart.sv
// tb_hw_stream_uart: self-checking bench for hw_stream_uart (default parameters).
module tb_hw_stream_uart;
    localparam int DATA_W = 8;
    localparam int TX_AW  = 6;
    localparam int RX_AW  = 6;

    // Clock and reset.
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hw_stream_uart_if #(.DATA_W(DATA_W)) bus ();

    hw_stream_uart #(.DATA_W(DATA_W), .TX_AW(TX_AW), .RX_AW(RX_AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int tx_xfers = 0;
    logic tx_valid_at_ack;
    logic [DATA_W-1:0] tx_exp_q[$];
    logic [DATA_W-1:0] rx_exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Driver: one Avalon access, called and returning just after a falling edge.
    task automatic av_access(input logic [1:0] addr, input logic is_read,
                             input logic [31:0] wdata, output logic [31:0] rdata);
        bus.av_address    = addr;
        bus.av_chipselect = 1'b1;
        bus.av_read_n     = ~is_read;
        bus.av_write_n    = is_read;
        bus.av_writedata  = wdata;
        @(posedge clk);
        @(negedge clk);
        check("waitreq_ack", 32'(bus.av_waitrequest), 32'd0);
        check("dbg_state_ack", 32'(bus.dbg_acc_state), 32'd1);
        tx_valid_at_ack = bus.tx_valid;
        rdata = bus.av_readdata;
        bus.av_chipselect = 1'b0;
        bus.av_read_n     = 1'b1;
        bus.av_write_n    = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic av_write(input logic [1:0] addr, input logic [31:0] wdata);
        logic [31:0] dummy;
        av_access(addr, 1'b0, wdata, dummy);
    endtask

    task automatic av_read(input logic [1:0] addr, output logic [31:0] rdata);
        av_access(addr, 1'b1, 32'd0, rdata);
    endtask

    // Driver: offer n RX words, one per cycle, while rx_ready is expected high.
    task automatic rx_push_words(input int n);
        for (int i = 0; i < n; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = DATA_W'($urandom_range(0, 255));
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
    endtask

    // Read one RX word via DATA and compare against the scoreboard head.
    task automatic rx_read_expect(input int level_before);
        logic [31:0] rd;
        logic [DATA_W-1:0] w;
        av_read(2'd0, rd);
        if (rx_exp_q.size() == 0) begin
            check("rx_sb_empty", 32'(rx_exp_q.size()), 32'd1);
        end else begin
            w = rx_exp_q.pop_front();
            check("rx_data_read", rd, {16'(level_before), 1'b1, 15'(w)});
        end
    endtask

    // Scoreboard monitors, sampled 1ns after the falling edge (inputs already settled).
    always @(negedge clk) begin
        #1;
        if (rst_n && bus.tx_valid && bus.tx_ready) begin
            tx_xfers++;
            if (tx_exp_q.size() == 0) check("tx_unexpected", 32'(bus.tx_data), 32'hFFFF_FFFF);
            else check("tx_stream_data", 32'(bus.tx_data), 32'(tx_exp_q.pop_front()));
        end
        if (rst_n && bus.rx_valid && bus.rx_ready) rx_exp_q.push_back(bus.rx_data);
    end

    // Watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] held;
        int xfers0;
        int waited;

        bus.av_address    = '0;
        bus.av_chipselect = 1'b0;
        bus.av_read_n     = 1'b1;
        bus.av_write_n    = 1'b1;
        bus.av_writedata  = '0;
        bus.tx_ready      = 1'b0;
        bus.rx_valid      = 1'b0;
        bus.rx_data       = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_waitreq", 32'(bus.av_waitrequest), 32'd1);
        check("rst_readdata", bus.av_readdata, 32'd0);
        check("rst_irq", 32'(bus.av_irq), 32'd0);
        check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
        check("rst_dbg_state", 32'(bus.dbg_acc_state), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        // Empty TX sits at or below TX_THR=8, so IP_TX reads as set.
        av_read(2'd1, rd);  check("rst_ctrl", rd, 32'h0040_0200);
        av_read(2'd2, rd);  check("rst_thr", rd, 32'h0008_0008);
        av_read(2'd3, rd);  check("rst_level", rd, 32'd0);

        // Single TX word: appears two cycles after the begin cycle, held while stalled.
        tx_exp_q.push_back(8'hA5);
        av_write(2'd0, 32'h0000_00A5);
        check("tx_valid_at_ack", 32'(tx_valid_at_ack), 32'd0);
        check("tx_valid_2cyc", 32'(bus.tx_valid), 32'd1);
        check("tx_data_2cyc", 32'(bus.tx_data), 32'h0000_00A5);
        repeat (3) begin
            @(negedge clk);
            check("tx_hold_valid", 32'(bus.tx_valid), 32'd1);
            check("tx_hold_data", 32'(bus.tx_data), 32'h0000_00A5);
        end
        xfers0 = tx_xfers;
        bus.tx_ready = 1'b1;
        @(negedge clk);
        check("tx_valid_after_xfer", 32'(bus.tx_valid), 32'd0);
        check("tx_single_xfer", 32'(tx_xfers - xfers0), 32'd1);
        bus.tx_ready = 1'b0;

        // Back-to-back drain: three words leave in three consecutive cycles.
        for (int i = 0; i < 3; i++) begin
            d = DATA_W'($urandom_range(0, 255));
            tx_exp_q.push_back(d);
            av_write(2'd0, 32'(d));
        end
        held = bus.tx_data;
        @(negedge clk);
        check("tx_stall_stable", 32'(bus.tx_data), 32'(held));
        xfers0 = tx_xfers;
        bus.tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("tx_b2b_count", 32'(tx_xfers - xfers0), 32'd3);
        check("tx_b2b_empty", 32'(bus.tx_valid), 32'd0);
        bus.tx_ready = 1'b0;

        // TX overflow: 65th word dropped, sticky flag, write-1-clear.
        for (int i = 0; i < 65; i++) begin
            d = DATA_W'($urandom_range(0, 255));
            if (i < 64) tx_exp_q.push_back(d);
            av_write(2'd0, 32'(d));
        end
        av_read(2'd1, rd);  check("ovf_ctrl", rd, 32'h0000_0400);
        av_read(2'd3, rd);  check("ovf_level", rd, 32'h0000_0040);
        av_write(2'd1, 32'h0000_0400);
        av_read(2'd1, rd);  check("ovf_cleared", rd, 32'h0000_0000);
        bus.tx_ready = 1'b1;
        waited = 0;
        while (tx_exp_q.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("tx_drain_done", 32'(tx_exp_q.size()), 32'd0);
        @(negedge clk);
        bus.tx_ready = 1'b0;
        av_read(2'd3, rd);  check("tx_drained_level", rd, 32'd0);
        av_read(2'd1, rd);  check("tx_drained_ctrl", rd, 32'h0040_0200);

        // RX fill to full, then drain in order, then underflow.
        rx_push_words(64);
        check("rx_ready_full", 32'(bus.rx_ready), 32'd0);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h5A;
        repeat (2) @(negedge clk);
        bus.rx_valid = 1'b0;
        check("rx_no_push_full", 32'(rx_exp_q.size()), 32'd64);
        av_read(2'd3, rd);  check("rx_full_level", rd, 32'h0040_0000);
        for (int k = 0; k < 64; k++) rx_read_expect(64 - k);
        av_read(2'd0, rd);  check("rx_underflow_read", rd, 32'd0);
        av_read(2'd1, rd);  check("rx_unf_ctrl", rd, 32'h0040_0A00);
        av_write(2'd1, 32'h0000_0800);
        av_read(2'd1, rd);  check("rx_unf_cleared", rd, 32'h0040_0200);

        // RX threshold interrupt.
        av_write(2'd1, 32'h0000_0001);
        av_write(2'd2, 32'h0008_0003);
        check("irq_rx_idle", 32'(bus.av_irq), 32'd0);
        rx_push_words(3);
        @(negedge clk);
        check("irq_rx_thr", 32'(bus.av_irq), 32'd1);
        rx_read_expect(3);
        check("irq_rx_below", 32'(bus.av_irq), 32'd0);
        rx_read_expect(2);
        rx_read_expect(1);

        // TX-level and error interrupt enables.
        av_write(2'd1, 32'h0000_0002);
        check("irq_tx_empty", 32'(bus.av_irq), 32'd1);
        av_write(2'd1, 32'h0000_0004);
        check("irq_err_none", 32'(bus.av_irq), 32'd0);
        av_read(2'd0, rd);
        check("irq_err_unf", 32'(bus.av_irq), 32'd1);
        av_write(2'd1, 32'h0000_0800);
        check("irq_err_cleared", 32'(bus.av_irq), 32'd0);

`ifdef HW_STREAM_UART_RXTO_EN
        // RX idle timeout.
        av_write(2'd3, 32'd10);
        av_write(2'd1, 32'h0000_0008);
        rx_push_words(1);
        repeat (5) @(negedge clk);
        check("rxto_early", 32'(bus.av_irq), 32'd0);
        waited = 0;
        while (!bus.av_irq && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        check("rxto_irq", 32'(bus.av_irq), 32'd1);
        av_read(2'd1, rd);  check("rxto_ip_bit", 32'(rd[12]), 32'd1);
        rx_read_expect(1);
        check("rxto_irq_cleared", 32'(bus.av_irq), 32'd0);
        av_write(2'd1, 32'h0000_0000);
`endif

        // Reset during activity: contents discarded, begun access aborted.
        for (int i = 0; i < 2; i++) av_write(2'd0, 32'(i + 1));
        rx_push_words(2);
        av_write(2'd2, 32'h0001_0001);
        rst_n             = 1'b0;
        bus.av_address    = 2'd0;
        bus.av_chipselect = 1'b1;
        bus.av_write_n    = 1'b0;
        bus.av_writedata  = 32'h0000_0077;
        @(negedge clk);
        check("mid_rst_waitreq", 32'(bus.av_waitrequest), 32'd1);
        check("mid_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("mid_rst_rx_ready", 32'(bus.rx_ready), 32'd1);
        check("mid_rst_readdata", bus.av_readdata, 32'd0);
        bus.av_chipselect = 1'b0;
        bus.av_write_n    = 1'b1;
        rst_n             = 1'b1;
        tx_exp_q.delete();
        rx_exp_q.delete();
        @(negedge clk);
        av_read(2'd3, rd);  check("mid_rst_level", rd, 32'd0);
        av_read(2'd2, rd);  check("mid_rst_thr", rd, 32'h0008_0008);
        check("mid_rst_tx_idle", 32'(bus.tx_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
